// File: rtl/musb_mem_access_unit.sv
// MEM-stage data-port controller: bus handshake, big-endian load formatting, address errors and LL/SC link.
// Define MUSB_BUS_ERROR_EN to report dport_error as exc_bus_error; otherwise the bus error input is ignored.
module musb_mem_access_unit #(
  parameter logic [31:0] USER_ADDR_LIMIT = 32'h8000_0000,
  parameter int unsigned LINK_LSB        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_mem_store_data,
  input  logic        mem_mem_write,
  input  logic        mem_mem_to_gpr_select,
  input  logic        mem_mem_byte,
  input  logic        mem_mem_halfword,
  input  logic        mem_mem_data_sign_ext,
  input  logic        mem_llsc,
  input  logic        mem_kernel_mode,
  input  logic        mem_flush,
  input  logic        mem_stall,
  input  logic        mem_llsc_clear,
  output logic [31:0] dport_address,
  output logic [31:0] dport_data_o,
  output logic [3:0]  dport_wr,
  output logic        dport_enable,
  input  logic [31:0] dport_data_i,
  input  logic        dport_ready,
  input  logic        dport_error,
  output logic [31:0] mem_read_data,
  output logic        mem_stall_req,
  output logic        exc_address_load,
  output logic        exc_address_store,
  output logic        exc_bus_error
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q;
  logic                 link_q;
  logic [31:LINK_LSB]   link_addr_q;
  logic [31:0]          rdata_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           wr_q;
  logic                 byte_q;
  logic                 half_q;
  logic                 sext_q;
  logic                 sc_q;
  logic                 ll_q;
  logic                 flushed_q;

  logic        in_idle;
  logic        in_busy;
  logic        is_load;
  logic        is_store;
  logic        is_sc;
  logic        is_ll;
  logic        misaligned;
  logic        priv_err;
  logic        addr_err;
  logic        link_ok;
  logic        start;
  logic        complete;
  logic        bus_err;
  logic        discard;
  logic        link_set;
  logic        link_clear;
  logic [3:0]  be_req;
  logic [31:0] wdata_req;

  logic        cur_byte;
  logic        cur_half;
  logic        cur_sext;
  logic        cur_sc;
  logic        cur_sc_ok;
  logic        cur_ll;
  logic [1:0]  cur_off;
  logic [31:0] cur_addr;
  logic [31:0] raw_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_fmt;

  assign in_idle  = (state_q == IDLE);
  assign in_busy  = (state_q == BUSY);
  assign is_load  = mem_mem_to_gpr_select;
  assign is_store = mem_mem_write;
  assign is_sc    = is_store & mem_llsc;
  assign is_ll    = is_load & mem_llsc;

  always_comb begin
    misaligned = 1'b0;
    if (mem_mem_byte) begin
      misaligned = 1'b0;
    end else if (mem_mem_halfword) begin
      misaligned = mem_alu_result[0];
    end else begin
      misaligned = |mem_alu_result[1:0];
    end
  end

  assign priv_err = ~mem_kernel_mode & (mem_alu_result >= USER_ADDR_LIMIT);
  assign addr_err = (is_load | is_store) & (misaligned | priv_err);
  assign link_ok  = link_q & (mem_alu_result[31:LINK_LSB] == link_addr_q);

  // A failed SC never reaches the bus; its result is produced in the same cycle.
  assign start = in_idle & (is_load | is_store) & ~addr_err & ~mem_flush & ~(is_sc & ~link_ok);

  always_comb begin
    be_req    = 4'b1111;
    wdata_req = mem_mem_store_data;
    if (mem_mem_byte) begin
      be_req    = 4'b1000 >> mem_alu_result[1:0];
      wdata_req = {4{mem_mem_store_data[7:0]}};
    end else if (mem_mem_halfword) begin
      be_req    = 4'b1100 >> {mem_alu_result[1], 1'b0};
      wdata_req = {2{mem_mem_store_data[15:0]}};
    end
  end

  // Once an access is on the bus, its attributes come from the latched copy.
  always_comb begin
    if (in_idle) begin
      cur_byte  = mem_mem_byte;
      cur_half  = mem_mem_halfword;
      cur_sext  = mem_mem_data_sign_ext;
      cur_sc    = is_sc;
      cur_sc_ok = link_ok;
      cur_ll    = is_ll;
      cur_off   = mem_alu_result[1:0];
      cur_addr  = mem_alu_result;
    end else begin
      cur_byte  = byte_q;
      cur_half  = half_q;
      cur_sext  = sext_q;
      cur_sc    = sc_q;
      cur_sc_ok = 1'b1;
      cur_ll    = ll_q;
      cur_off   = addr_q[1:0];
      cur_addr  = addr_q;
    end
  end

  assign complete = (start | in_busy) & dport_ready;
  assign discard  = in_busy & (flushed_q | mem_flush);

`ifdef MUSB_BUS_ERROR_EN
  assign bus_err = complete & dport_error;
`else
  logic unused_bus_error;
  assign unused_bus_error = dport_error;
  assign bus_err          = 1'b0;
`endif

  assign link_set   = complete & cur_ll & ~bus_err & ~discard;
  assign link_clear = mem_llsc_clear | (in_idle & is_sc & ~addr_err & ~mem_flush);

  assign raw_data = complete ? (bus_err ? 32'd0 : dport_data_i) : rdata_q;

  always_comb begin
    case (cur_off)
      2'd0:    sel_byte = raw_data[31:24];
      2'd1:    sel_byte = raw_data[23:16];
      2'd2:    sel_byte = raw_data[15:8];
      default: sel_byte = raw_data[7:0];
    endcase
    sel_half = cur_off[1] ? raw_data[15:0] : raw_data[31:16];
    if (cur_byte) begin
      load_fmt = {{24{cur_sext & sel_byte[7]}}, sel_byte};
    end else if (cur_half) begin
      load_fmt = {{16{cur_sext & sel_half[15]}}, sel_half};
    end else begin
      load_fmt = raw_data;
    end
  end

  // Reset forces every output low immediately, even with a request still presented.
  always_comb begin
    dport_address     = 32'd0;
    dport_data_o      = 32'd0;
    dport_wr          = 4'd0;
    dport_enable      = 1'b0;
    mem_read_data     = 32'd0;
    mem_stall_req     = 1'b0;
    exc_address_load  = 1'b0;
    exc_address_store = 1'b0;
    exc_bus_error     = 1'b0;
    if (!rst) begin
      dport_enable      = start | in_busy;
      dport_address     = {cur_addr[31:2], 2'b00};
      dport_data_o      = in_idle ? wdata_req : wdata_q;
      if (start) begin
        dport_wr = is_store ? be_req : 4'd0;
      end else if (in_busy) begin
        dport_wr = wr_q;
      end
      mem_stall_req     = (start | in_busy) & ~dport_ready;
      mem_read_data     = cur_sc ? {31'd0, cur_sc_ok} : load_fmt;
      exc_address_load  = in_idle & is_load & addr_err & ~mem_flush;
      exc_address_store = in_idle & is_store & addr_err & ~mem_flush;
      exc_bus_error     = bus_err & ~discard;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      link_q      <= 1'b0;
      link_addr_q <= '0;
      rdata_q     <= 32'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wr_q        <= 4'd0;
      byte_q      <= 1'b0;
      half_q      <= 1'b0;
      sext_q      <= 1'b0;
      sc_q        <= 1'b0;
      ll_q        <= 1'b0;
      flushed_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q    <= mem_alu_result;
            wdata_q   <= wdata_req;
            wr_q      <= is_store ? be_req : 4'd0;
            byte_q    <= mem_mem_byte;
            half_q    <= mem_mem_halfword;
            sext_q    <= mem_mem_data_sign_ext;
            sc_q      <= is_sc;
            ll_q      <= is_ll;
            flushed_q <= 1'b0;
            if (dport_ready) begin
              state_q <= mem_stall ? DONE : IDLE;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          flushed_q <= flushed_q | mem_flush;
          if (dport_ready) begin
            state_q <= mem_stall ? DONE : IDLE;
          end
        end
        DONE: begin
          if (!mem_stall) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (complete) begin
        rdata_q <= bus_err ? 32'd0 : dport_data_i;
      end

      if (link_clear) begin
        link_q <= 1'b0;
      end else if (link_set) begin
        link_q      <= 1'b1;
        link_addr_q <= cur_addr[31:LINK_LSB];
      end
    end
  end

endmodule
